// File: rtl/ctrl_unit_pipe.sv
// Decode-stage control unit with a registered D/E boundary and an optional MUL/DIV occupancy sequencer.
// Define CTRL_UNIT_PIPE_MDU_EN to enable M-extension decode, the sequencer and MDU_BUSY.
module ctrl_unit_pipe #(
  parameter int INST_SIZE   = 32,
  parameter int ALU_CTRL_W  = 4,
  parameter int MDU_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_SIZE-1:0]  InstrD,
  input  logic                  VALID_D,
  input  logic                  STALL,
  input  logic                  FLUSH,
  output logic [ALU_CTRL_W-1:0] ALU_CONTROL_E,
  output logic [1:0]            ALU_SRC2_E,
  output logic                  BRN_COND_E,
  output logic                  MEM_WE_E,
  output logic                  DE_WE_E,
  output logic                  MEM_REG_E,
  output logic                  MDU_E,
  output logic                  ILLEGAL_E,
  output logic                  VALID_E,
  output logic                  MDU_BUSY
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SRA = 4'd7;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ok;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7    = InstrD[31:25];
  assign unused_ok = ^InstrD;

  // Non-SUB/SRA ALU code for a funct3 slot of R-type and OP-IMM.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = 4'd0;
      3'b001:  alu_base = 4'd2;
      3'b010:  alu_base = 4'd3;
      3'b011:  alu_base = 4'd4;
      3'b100:  alu_base = 4'd5;
      3'b101:  alu_base = 4'd6;
      3'b110:  alu_base = 4'd8;
      default: alu_base = 4'd9;
    endcase
  endfunction

  logic [ALU_CTRL_W-1:0] alu_d, alu_q;
  logic [1:0]            src2_d, src2_q;
  logic [3:0]            alu_code;
  logic brn_d, memwe_d, dewe_d, memreg_d, mdu_d, ill_d, valid_d, illegal;
  logic brn_q, memwe_q, dewe_q, memreg_q, mdu_q, ill_q, valid_q;

  always_comb begin
    alu_code = ALU_ADD;
    src2_d   = 2'b00;
    brn_d    = 1'b0;
    memwe_d  = 1'b0;
    dewe_d   = 1'b0;
    memreg_d = 1'b0;
    mdu_d    = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_R: begin
        dewe_d = 1'b1;
        if (funct7 == 7'b0000000) alu_code = alu_base(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) alu_code = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) alu_code = ALU_SRA;
`ifdef CTRL_UNIT_PIPE_MDU_EN
        else if (funct7 == 7'b0000001) begin
          mdu_d    = 1'b1;
          alu_code = {1'b0, funct3};
        end
`endif
        else illegal = 1'b1;
      end
      OPC_IMM: begin
        dewe_d   = 1'b1;
        src2_d   = 2'b01;
        alu_code = (funct3 == 3'b101 && funct7 == 7'b0100000) ? ALU_SRA : alu_base(funct3);
      end
      OPC_LOAD: begin
        dewe_d   = 1'b1;
        memreg_d = 1'b1;
        src2_d   = 2'b01;
      end
      OPC_STORE: begin
        memwe_d = 1'b1;
        src2_d  = 2'b01;
      end
      OPC_BRANCH: begin
        brn_d    = 1'b1;
        alu_code = ALU_SUB;
      end
      OPC_JAL, OPC_JALR: begin
        brn_d  = 1'b1;
        dewe_d = 1'b1;
        src2_d = 2'b10;
      end
      OPC_LUI, OPC_AUIPC: begin
        dewe_d = 1'b1;
        src2_d = 2'b01;
      end
      default: illegal = 1'b1;
    endcase

    ill_d   = 1'b0;
    valid_d = VALID_D;
    // A bubble or an illegal op must not leave any side-effecting control asserted.
    if (!VALID_D || illegal) begin
      alu_code = 4'd0;
      src2_d   = 2'b00;
      brn_d    = 1'b0;
      memwe_d  = 1'b0;
      dewe_d   = 1'b0;
      memreg_d = 1'b0;
      mdu_d    = 1'b0;
      ill_d    = VALID_D & illegal;
    end
    alu_d      = '0;
    alu_d[3:0] = alu_code;
  end

  logic busy;

`ifdef CTRL_UNIT_PIPE_MDU_EN
  localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MDU_LATENCY > 1) ? MDU_LATENCY - 2 : 0);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (FLUSH) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (state_q == S_BUSY) begin
      if (cnt_q == '0) state_q <= S_IDLE;
      else             cnt_q   <= cnt_q - CNT_W'(1);
    end else if (!STALL && mdu_d && (MDU_LATENCY > 1)) begin
      state_q <= S_BUSY;
      cnt_q   <= CNT_INIT;
    end
  end

  assign busy = (state_q == S_BUSY);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FLUSH) begin
      alu_q    <= '0;
      src2_q   <= 2'b00;
      brn_q    <= 1'b0;
      memwe_q  <= 1'b0;
      dewe_q   <= 1'b0;
      memreg_q <= 1'b0;
      mdu_q    <= 1'b0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else if (!busy && !STALL) begin
      alu_q    <= alu_d;
      src2_q   <= src2_d;
      brn_q    <= brn_d;
      memwe_q  <= memwe_d;
      dewe_q   <= dewe_d;
      memreg_q <= memreg_d;
      mdu_q    <= mdu_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

  assign ALU_CONTROL_E = alu_q;
  assign ALU_SRC2_E    = src2_q;
  assign BRN_COND_E    = brn_q;
  assign MEM_WE_E      = memwe_q;
  assign DE_WE_E       = dewe_q;
  assign MEM_REG_E     = memreg_q;
  assign MDU_E         = mdu_q;
  assign ILLEGAL_E     = ill_q;
  assign VALID_E       = valid_q;
  assign MDU_BUSY      = busy;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed-vector bench for ctrl_unit_pipe; MUL/DIV sequencing checks run when CTRL_UNIT_PIPE_MDU_EN is defined.
module tb_ctrl_unit_pipe;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        VALID_D, STALL, FLUSH;
  logic [3:0]  ALU_CONTROL_E;
  logic [1:0]  ALU_SRC2_E;
  logic        BRN_COND_E, MEM_WE_E, DE_WE_E, MEM_REG_E, MDU_E, ILLEGAL_E, VALID_E, MDU_BUSY;

  always #5 clk = ~clk;

  ctrl_unit_pipe #(.INST_SIZE(32), .ALU_CTRL_W(4), .MDU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .VALID_D(VALID_D), .STALL(STALL), .FLUSH(FLUSH),
    .ALU_CONTROL_E(ALU_CONTROL_E), .ALU_SRC2_E(ALU_SRC2_E), .BRN_COND_E(BRN_COND_E),
    .MEM_WE_E(MEM_WE_E), .DE_WE_E(DE_WE_E), .MEM_REG_E(MEM_REG_E), .MDU_E(MDU_E),
    .ILLEGAL_E(ILLEGAL_E), .VALID_E(VALID_E), .MDU_BUSY(MDU_BUSY)
  );

  // Bundle order: alu[3:0], src2[1:0], brn, mem_we, de_we, mem_reg, mdu, illegal, valid
  logic [12:0] e_bundle;
  assign e_bundle = {ALU_CONTROL_E, ALU_SRC2_E, BRN_COND_E, MEM_WE_E, DE_WE_E,
                     MEM_REG_E, MDU_E, ILLEGAL_E, VALID_E};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] b(input logic [3:0] alu, input logic [1:0] s2, input logic brn,
                                    input logic mw, input logic dw, input logic mr, input logic md,
                                    input logic il, input logic v);
    return {alu, s2, brn, mw, dw, mr, md, il, v};
  endfunction

  task automatic add(input string n, input logic [31:0] i, input logic v, input logic s,
                     input logic f, input logic [12:0] e);
    vec_t t;
    t.name = n; t.instr = i; t.valid = v; t.stall = s; t.flush = f; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic check_bundle(input string n, input logic [12:0] exp);
    checks++;
    if (e_bundle !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, e_bundle, exp);
    end else begin
      $display("ok   %s: bundle %b", n, e_bundle);
    end
  endtask

  task automatic check_busy(input string n, input logic exp);
    checks++;
    if (MDU_BUSY !== exp) begin
      errors++;
      $display("FAIL %s MDU_BUSY: got %b expected %b", n, MDU_BUSY, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    InstrD = i; VALID_D = v; STALL = s; FLUSH = f;
  endtask

  logic [12:0] ILL;
  assign ILL = b(4'd0, 2'b00, 0, 0, 0, 0, 0, 1, 1);

  initial begin
    rst = 1'b1;
    drive(32'h0, 0, 0, 0);
    add("add",       32'h00B50533, 1, 0, 0, b(4'd0, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("sub",       32'h40B50533, 1, 0, 0, b(4'd1, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("sll",       32'h00B51533, 1, 0, 0, b(4'd2, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("slt",       32'h00B52533, 1, 0, 0, b(4'd3, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("sltu",      32'h00B53533, 1, 0, 0, b(4'd4, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("xor",       32'h00B54533, 1, 0, 0, b(4'd5, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("srl",       32'h00B55533, 1, 0, 0, b(4'd6, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("sra",       32'h40B55533, 1, 0, 0, b(4'd7, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("or",        32'h00B56533, 1, 0, 0, b(4'd8, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("and",       32'h00B57533, 1, 0, 0, b(4'd9, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("addi_400",  32'h40058513, 1, 0, 0, b(4'd0, 2'b01, 0, 0, 1, 0, 0, 0, 1));
    add("ori",       32'h0015E513, 1, 0, 0, b(4'd8, 2'b01, 0, 0, 1, 0, 0, 0, 1));
    add("srai",      32'h4015D513, 1, 0, 0, b(4'd7, 2'b01, 0, 0, 1, 0, 0, 0, 1));
    add("lw",        32'h0005A503, 1, 0, 0, b(4'd0, 2'b01, 0, 0, 1, 1, 0, 0, 1));
    add("sw",        32'h00A5A023, 1, 0, 0, b(4'd0, 2'b01, 0, 1, 0, 0, 0, 0, 1));
    add("beq",       32'h00B50463, 1, 0, 0, b(4'd1, 2'b00, 1, 0, 0, 0, 0, 0, 1));
    add("jal",       32'h008000EF, 1, 0, 0, b(4'd0, 2'b10, 1, 0, 1, 0, 0, 0, 1));
    add("jalr",      32'h000080E7, 1, 0, 0, b(4'd0, 2'b10, 1, 0, 1, 0, 0, 0, 1));
    add("lui",       32'h123452B7, 1, 0, 0, b(4'd0, 2'b01, 0, 0, 1, 0, 0, 0, 1));
    add("auipc",     32'h00001517, 1, 0, 0, b(4'd0, 2'b01, 0, 0, 1, 0, 0, 0, 1));
    add("bubble",    32'h00B50533, 0, 0, 0, 13'd0);
    add("ill_opc",   32'h0000007F, 1, 0, 0, ILL);
    add("stall1",    32'h40B50533, 1, 1, 0, ILL);
    add("stall2",    32'h00A5A023, 1, 1, 0, ILL);
    add("sub_again", 32'h40B50533, 1, 0, 0, b(4'd1, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    add("flush",     32'h00B50533, 1, 0, 1, 13'd0);
    add("bad_f7",    32'h20B50533, 1, 0, 0, ILL);
    add("stall_f7",  32'h00B57533, 1, 1, 0, ILL);
`ifndef CTRL_UNIT_PIPE_MDU_EN
    add("mul_nomdu", 32'h02B50533, 1, 0, 0, ILL);
`endif
    add("and_last",  32'h00B57533, 1, 0, 0, b(4'd9, 2'b00, 0, 0, 1, 0, 0, 0, 1));

    repeat (2) @(negedge clk);
    check_bundle("reset", 13'd0);
    check_busy("reset", 1'b0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].valid, vecs[k].stall, vecs[k].flush);
      step();
      check_bundle(vecs[k].name, vecs[k].exp);
      check_busy(vecs[k].name, 1'b0);
    end

    // Asynchronous reset asserted mid-cycle must clear E before the next edge.
    drive(32'h00B50533, 1, 0, 0);
    step();
    check_bundle("pre_rst_add", b(4'd0, 2'b00, 0, 0, 1, 0, 0, 0, 1));
    drive(32'h0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_bundle("async_rst", 13'd0);
    check_busy("async_rst", 1'b0);
    #1 rst = 1'b0;
    step();

`ifdef CTRL_UNIT_PIPE_MDU_EN
    begin
      logic [12:0] mul_e;
      logic [12:0] add_e;
      logic [12:0] sub_e;
      mul_e = b(4'd0, 2'b00, 0, 0, 1, 0, 1, 0, 1);
      add_e = b(4'd0, 2'b00, 0, 0, 1, 0, 0, 0, 1);
      sub_e = b(4'd1, 2'b00, 0, 0, 1, 0, 0, 0, 1);

      // mul occupies E for LAT cycles; the following add appears in cycle LAT+1.
      drive(32'h02B50533, 1, 0, 0);
      step();
      drive(32'h00B50533, 1, 0, 0);
      for (int c = 1; c <= LAT; c++) begin
        check_bundle($sformatf("mul_hold_c%0d", c), mul_e);
        check_busy($sformatf("mul_hold_c%0d", c), (c < LAT) ? 1'b1 : 1'b0);
        if (c == 2) STALL = 1'b1;
        step();
        STALL = 1'b0;
      end
      check_bundle("after_mul_add", add_e);
      check_busy("after_mul_add", 1'b0);

      // FLUSH in the second BUSY cycle aborts the op.
      drive(32'h02B54533, 1, 0, 0);
      step();
      check_bundle("div_c1", b(4'd4, 2'b00, 0, 0, 1, 0, 1, 0, 1));
      check_busy("div_c1", 1'b1);
      step();
      check_busy("div_c2", 1'b1);
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      check_bundle("div_flushed", 13'd0);
      check_busy("div_flushed", 1'b0);
      drive(32'h40B50533, 1, 0, 0);
      step();
      check_bundle("post_flush_sub", sub_e);
      check_busy("post_flush_sub", 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
